// File: rtl/dmem_pkg.sv
// Shared state encoding, default widths and the abort data word for the dmem response controller.
// Defining DMEM_WBUF_EN adds the DRAIN state used by the posted write buffer.
package dmem_pkg;

  localparam int DMEM_ADDR_W  = 16;
  localparam int DMEM_DATA_W  = 16;
  localparam int DMEM_TIMEOUT = 15;

  localparam logic [15:0] ERR_DATA = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2
`ifdef DMEM_WBUF_EN
    ,
    ST_DRAIN = 2'd3
`endif
  } dmem_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// Single-entry posted write buffer with address match for load forwarding.
// Only instantiated when DMEM_WBUF_EN is defined.
module dmem_wbuf
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              match
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  assign match = valid && (addr == lookup_addr);

endmodule

// File: rtl/dmem_resp_ctrl.sv
// MEM-stage data-memory response controller: stalls the pipeline around each access, with timeout abort.
// Defining DMEM_WBUF_EN posts stores through a single-entry write buffer drained in DRAIN.
module dmem_resp_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int TIMEOUT = DMEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  dmem_state_e       state_q, state_d;
  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_inc;
  logic              tmo_q;
  logic              tmo_hit;
  logic              accept;
  logic              cnt_clr;

  assign cnt_inc = sat_inc8(cnt_q);
  // The access is abandoned in the cycle whose increment would reach TIMEOUT, so exactly TIMEOUT WAIT cycles drive mem_en.
  assign tmo_hit = !mem_ack && (cnt_inc >= TIMEOUT_CNT);

`ifdef DMEM_WBUF_EN
  logic              wb_valid;
  logic              wb_match;
  logic              wb_load;
  logic              wb_clear;
  logic              fwd_q;
  logic              fwd_d;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  dmem_wbuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wbuf (
    .clk         (clk),
    .rst         (rst),
    .load        (wb_load),
    .clear       (wb_clear),
    .load_addr   (req_addr),
    .load_data   (req_wdata),
    .lookup_addr (req_addr),
    .valid       (wb_valid),
    .addr        (wb_addr),
    .data        (wb_data),
    .match       (wb_match)
  );

  assign cnt_clr   = accept | wb_load;
  assign mem_wr    = mem_en & ((state_q == ST_DRAIN) | op_wr_q);
  assign mem_addr  = (state_q == ST_DRAIN) ? wb_addr : addr_q;
  assign mem_wdata = (state_q == ST_DRAIN) ? wb_data : wdata_q;
`else
  assign cnt_clr   = accept;
  assign mem_wr    = mem_en & op_wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
`endif

  assign rd_data = rd_data_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    stall    = 1'b0;
    rd_valid = 1'b0;
    err      = 1'b0;
    mem_en   = 1'b0;
    accept   = 1'b0;
`ifdef DMEM_WBUF_EN
    wb_load  = 1'b0;
    wb_clear = 1'b0;
    fwd_d    = 1'b0;
`endif
    // Reset silences the combinational outputs at once, even with a request still on the inputs.
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
`ifdef DMEM_WBUF_EN
          // A forwarded load is completing this cycle; the pipeline advances past it.
          if (!fwd_q) begin
            if (req_rd && req_wr) begin
              err = 1'b1;
            end else if (req_wr && !wb_valid) begin
              wb_load = 1'b1;
              state_d = ST_DRAIN;
            end else if (req_rd || req_wr) begin
              stall   = 1'b1;
              accept  = 1'b1;
              state_d = ST_WAIT;
            end
          end
`else
          if (req_rd && req_wr) begin
            err = 1'b1;
          end else if (req_rd || req_wr) begin
            stall   = 1'b1;
            accept  = 1'b1;
            state_d = ST_WAIT;
          end
`endif
        end
        ST_WAIT: begin
          mem_en = 1'b1;
          stall  = 1'b1;
          if (mem_ack || tmo_hit) state_d = ST_DONE;
        end
        ST_DONE: begin
          rd_valid = !op_wr_q;
          err      = tmo_q;
          state_d  = ST_IDLE;
        end
`ifdef DMEM_WBUF_EN
        ST_DRAIN: begin
          mem_en = 1'b1;
          if (wb_valid && !fwd_q && (req_rd || req_wr)) begin
            stall = 1'b1;
            fwd_d = req_rd && !req_wr && wb_match;
          end
          if (mem_ack || tmo_hit) begin
            wb_clear = 1'b1;
            err      = tmo_hit;
            state_d  = ST_IDLE;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
`ifdef DMEM_WBUF_EN
      rd_valid = rd_valid | fwd_q;
`endif
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_wr_q <= req_wr;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        tmo_q   <= 1'b0;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (mem_en) begin
        cnt_q <= cnt_inc;
      end
      if (state_q == ST_WAIT) begin
        if (mem_ack) begin
          if (!op_wr_q) rd_data_q <= mem_rdata;
        end else if (tmo_hit) begin
          tmo_q <= 1'b1;
          if (!op_wr_q) rd_data_q <= DATA_W'(ERR_DATA);
        end
      end
`ifdef DMEM_WBUF_EN
      if (fwd_d) rd_data_q <= wb_data;
`endif
    end
  end

`ifdef DMEM_WBUF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fwd_q <= 1'b0;
    else     fwd_q <= fwd_d;
  end
`endif

endmodule

// File: tb/tb_dmem_resp_ctrl.sv
// Self-checking bench for dmem_resp_ctrl: directed cycle table, timeout/reset sequences, random transactions.
// Directed table switches to the write-buffer scenario when DMEM_WBUF_EN is defined.
module tb_dmem_resp_ctrl;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_rd = 1'b0, req_wr = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        stall, rd_valid, err, mem_en, mem_wr;
  logic [15:0] rd_data, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  dmem_resp_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_rd    (req_rd),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .err       (err),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [15:0] addr, wdata;
    logic        ack;
    logic [15:0] rdata;
    logic        x_stall, x_rv;
    logic [15:0] x_rdd;
    logic        x_err, x_en, x_wr;
    logic [15:0] x_addr, x_wdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic ack, input logic [15:0] rdata,
                              input logic x_stall, input logic x_rv, input logic [15:0] x_rdd,
                              input logic x_err, input logic x_en, input logic x_wr,
                              input logic [15:0] x_addr, input logic [15:0] x_wdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.ack = ack; v.rdata = rdata;
    v.x_stall = x_stall; v.x_rv = x_rv; v.x_rdd = x_rdd; v.x_err = x_err;
    v.x_en = x_en; v.x_wr = x_wr; v.x_addr = x_addr; v.x_wdata = x_wdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                       input logic ack, input logic [15:0] rdat);
    req_rd    = rd;
    req_wr    = wr;
    req_addr  = a;
    req_wdata = d;
    mem_ack   = ack;
    mem_rdata = rdat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random-phase variables (static, assigned every iteration).
  int          kind, lat, waits, n;
  logic        is_wr, timed_out;
  logic [15:0] r_addr, r_wdata, r_rdat, model_rd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    @(negedge clk);
    check("reset stall", stall, 1'b0);
    check("reset rd_valid", rd_valid, 1'b0);
    check("reset err", err, 1'b0);
    check("reset mem_en", mem_en, 1'b0);
    check("reset mem_wr", mem_wr, 1'b0);
    check("reset mem_addr", mem_addr, 16'h0);
    check("reset mem_wdata", mem_wdata, 16'h0);
    check("reset rd_data", rd_data, 16'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // rd wr addr wdata ack rdata | stall rv rd_data err en wr mem_addr mem_wdata
    vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));
`ifdef DMEM_WBUF_EN
    vecs.push_back(mk(0, 1, 16'h0020, 16'hA5A5, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0020, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 1, 16'h0020, 16'hA5A5));
    vecs.push_back(mk(1, 0, 16'h0020, 16'h0000, 0, 16'h0000, 0, 1, 16'hA5A5, 0, 1, 1, 16'h0020, 16'hA5A5));
    vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 0, 0, 16'hA5A5, 0, 1, 1, 16'h0020, 16'hA5A5));
    vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'hA5A5, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0040, 16'h0000, 0, 16'h0000, 1, 0, 16'hA5A5, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0040, 16'h0000, 1, 16'hBEEF, 1, 0, 16'hA5A5, 0, 1, 0, 16'h0040, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0040, 16'h0000, 0, 16'h0000, 0, 1, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000));
`else
    vecs.push_back(mk(1, 0, 16'h0040, 16'h0000, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0040, 16'h0000, 1, 16'hBEEF, 1, 0, 16'h0000, 0, 1, 0, 16'h0040, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0040, 16'h0000, 0, 16'h0000, 0, 1, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 1, 16'h0010, 16'h1234, 0, 16'h0000, 1, 0, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 1, 16'h0010, 16'h1234, 0, 16'h0000, 1, 0, 16'hBEEF, 0, 1, 1, 16'h0010, 16'h1234));
    vecs.push_back(mk(0, 1, 16'h0010, 16'h1234, 0, 16'h0000, 1, 0, 16'hBEEF, 0, 1, 1, 16'h0010, 16'h1234));
    vecs.push_back(mk(0, 1, 16'h0010, 16'h1234, 1, 16'h5555, 1, 0, 16'hBEEF, 0, 1, 1, 16'h0010, 16'h1234));
    vecs.push_back(mk(0, 1, 16'h0010, 16'h1234, 0, 16'h0000, 0, 0, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000));
`endif
    vecs.push_back(mk(1, 1, 16'h0099, 16'h7777, 0, 16'h0000, 0, 0, 16'hBEEF, 1, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 1, 16'h0099, 16'h7777, 0, 16'h0000, 0, 0, 16'hBEEF, 1, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 16'h1111, 0, 0, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0002, 16'h0000, 1, 16'h9999, 1, 0, 16'hBEEF, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0002, 16'h0000, 0, 16'h2222, 1, 0, 16'hBEEF, 0, 1, 0, 16'h0002, 16'h0000));
    vecs.push_back(mk(1, 0, 16'h0002, 16'h0000, 1, 16'h3333, 1, 0, 16'hBEEF, 0, 1, 0, 16'h0002, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 16'h4444, 0, 1, 16'h3333, 0, 0, 0, 16'h0000, 16'h0000));
    vecs.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 16'h3333, 0, 0, 0, 16'h0000, 16'h0000));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].rdata);
      @(negedge clk);
      check($sformatf("vec%0d stall", i), stall, vecs[i].x_stall);
      check($sformatf("vec%0d rd_valid", i), rd_valid, vecs[i].x_rv);
      check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].x_rdd);
      check($sformatf("vec%0d err", i), err, vecs[i].x_err);
      check($sformatf("vec%0d mem_en", i), mem_en, vecs[i].x_en);
      check($sformatf("vec%0d mem_wr", i), mem_wr, vecs[i].x_wr);
      if (vecs[i].x_en) check($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].x_addr);
      if (vecs[i].x_wr) check($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].x_wdata);
      tick();
    end

    // Load with no ack: exactly TMO cycles of mem_en, then err and the abort word in DONE.
    drive(1, 0, 16'h0077, 16'h0000, 0, 16'h0000);
    @(negedge clk);
    check("tmo req stall", stall, 1'b1);
    check("tmo req mem_en", mem_en, 1'b0);
    tick();
    n = 0;
    @(negedge clk);
    while (mem_en && n < 40) begin
      n++;
      if (!stall) check("tmo wait stall", stall, 1'b1);
      tick();
      @(negedge clk);
    end
    check("tmo wait cycles", 16'(n), 16'(TMO));
    check("tmo done err", err, 1'b1);
    check("tmo done rd_valid", rd_valid, 1'b1);
    check("tmo done rd_data", rd_data, 16'hFFFF);
    check("tmo done stall", stall, 1'b0);
    tick();
    drive(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    @(negedge clk);
    check("tmo after err", err, 1'b0);
    check("tmo after rd_valid", rd_valid, 1'b0);
    check("tmo hold rd_data", rd_data, 16'hFFFF);
    tick();

    // Reset in the middle of WAIT, then a clean load.
    drive(1, 0, 16'h0055, 16'h0000, 0, 16'h0000);
    @(negedge clk);
    check("rst req stall", stall, 1'b1);
    tick();
    @(negedge clk);
    check("rst wait mem_en", mem_en, 1'b1);
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst async mem_en", mem_en, 1'b0);
    check("rst async stall", stall, 1'b0);
    check("rst async rd_valid", rd_valid, 1'b0);
    check("rst async err", err, 1'b0);
    check("rst async mem_addr", mem_addr, 16'h0);
    check("rst async rd_data", rd_data, 16'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
    @(negedge clk);
    check("post rst idle stall", stall, 1'b0);
    check("post rst idle mem_en", mem_en, 1'b0);
    tick();
    drive(1, 0, 16'h0060, 16'h0000, 0, 16'h0000);
    @(negedge clk);
    check("post rst req stall", stall, 1'b1);
    tick();
    drive(1, 0, 16'h0060, 16'h0000, 1, 16'hC0DE);
    @(negedge clk);
    check("post rst wait mem_en", mem_en, 1'b1);
    check("post rst mem_addr", mem_addr, 16'h0060);
    tick();
    drive(1, 0, 16'h0060, 16'h0000, 0, 16'h0000);
    @(negedge clk);
    check("post rst rd_valid", rd_valid, 1'b1);
    check("post rst rd_data", rd_data, 16'hC0DE);
    check("post rst err", err, 1'b0);
    check("post rst done stall", stall, 1'b0);
    tick();

    // Random transactions against a transaction-level model.
    model_rd = 16'hC0DE;
    for (int t = 0; t < 80; t++) begin
      kind    = int'($urandom_range(0, 3));
      lat     = int'($urandom_range(1, TMO + 3));
      r_addr  = 16'($urandom);
      r_wdata = 16'($urandom);
      r_rdat  = 16'($urandom);
`ifdef DMEM_WBUF_EN
      if (kind == 2) kind = 1;
`endif
      if (kind == 0) begin
        drive(0, 0, r_addr, r_wdata, 1'($urandom_range(0, 1)), 16'($urandom));
        @(negedge clk);
        check($sformatf("rnd%0d idle stall", t), stall, 1'b0);
        check($sformatf("rnd%0d idle mem_en", t), mem_en, 1'b0);
        check($sformatf("rnd%0d idle rd_valid", t), rd_valid, 1'b0);
        check($sformatf("rnd%0d idle rd_data", t), rd_data, model_rd);
        tick();
      end else if (kind == 3) begin
        drive(1, 1, r_addr, r_wdata, 1'($urandom_range(0, 1)), 16'($urandom));
        @(negedge clk);
        check($sformatf("rnd%0d both err", t), err, 1'b1);
        check($sformatf("rnd%0d both stall", t), stall, 1'b0);
        check($sformatf("rnd%0d both mem_en", t), mem_en, 1'b0);
        tick();
      end else begin
        is_wr     = (kind == 2);
        timed_out = (lat > TMO);
        waits     = timed_out ? TMO : lat;
        drive(!is_wr, is_wr, r_addr, r_wdata, 1'($urandom_range(0, 1)), 16'($urandom));
        @(negedge clk);
        check($sformatf("rnd%0d req stall", t), stall, 1'b1);
        check($sformatf("rnd%0d req mem_en", t), mem_en, 1'b0);
        tick();
        for (int k = 1; k <= waits; k++) begin
          drive(!is_wr, is_wr, r_addr, r_wdata, (k == lat), (k == lat) ? r_rdat : 16'($urandom));
          @(negedge clk);
          check($sformatf("rnd%0d w%0d mem_en", t, k), mem_en, 1'b1);
          check($sformatf("rnd%0d w%0d stall", t, k), stall, 1'b1);
          check($sformatf("rnd%0d w%0d mem_wr", t, k), mem_wr, is_wr);
          check($sformatf("rnd%0d w%0d mem_addr", t, k), mem_addr, r_addr);
          if (is_wr) check($sformatf("rnd%0d w%0d mem_wdata", t, k), mem_wdata, r_wdata);
          tick();
        end
        if (!is_wr) model_rd = timed_out ? 16'hFFFF : r_rdat;
        drive(!is_wr, is_wr, r_addr, r_wdata, 1'($urandom_range(0, 1)), 16'($urandom));
        @(negedge clk);
        check($sformatf("rnd%0d done stall", t), stall, 1'b0);
        check($sformatf("rnd%0d done mem_en", t), mem_en, 1'b0);
        check($sformatf("rnd%0d done rd_valid", t), rd_valid, !is_wr);
        check($sformatf("rnd%0d done err", t), err, timed_out);
        check($sformatf("rnd%0d done rd_data", t), rd_data, model_rd);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
